ami_decoder: RTL
================

# ami_decoder

Receive-side counterpart of the AMI line encoder. Samples one bipolar AMI symbol per enabled clock and decodes it to a binary bit (any mark → 1, zero → 0). Reassembles bits LSB-first into WORD_W-bit words. Flags bipolar violations and illegal symbol codes, and keeps a saturating violation count for link monitoring.

## Interface
- WORD_W, 16, bits per reassembled word; the first received symbol lands in bit 0.
- CNT_W, 8, width of the saturating violation counter.

- sys_clk  input  1  system clock; all state changes on the rising edge.
- sys_rst_n  input  1  asynchronous, active-low reset.
- en  input  1  1 = sample ami_i this cycle; 0 = idle and clear word alignment.
- ami_i  input  2 (signed)  line symbol: 2'b01 = +1, 2'b11 = −1, 2'b00 = 0, 2'b10 = illegal.
- data_o  output  WORD_W  last completed word; held until the next word completes.
- data_valid_o  output  1  one-cycle pulse when data_o is updated.
- bpv_o  output  1  one-cycle pulse: the sampled mark has the same polarity as the previous mark.
- err_sym_o  output  1  one-cycle pulse: the sampled symbol was 2'b10.
- bpv_cnt_o  output  CNT_W  saturating count of bipolar violations.

## Operation
- Polarity tracker FSM states:
  - NONE (after reset).
  - POS: last mark was +1.
  - NEG: last mark was −1.
- Tracker transitions, only on sampled symbols:
  - +1 → POS; −1 → NEG.
  - 0 and illegal: no change.
- Violation detection:
  - +1 in POS, or −1 in NEG, is a violation.
  - The first mark taken from NONE is never a violation.
  - A violating mark still decodes as 1 and still updates the tracker.
- Illegal symbol 2'b10: decodes as 0, pulses err_sym_o, never counts as a violation.
- Word reassembly:
  - Shift register fills from the MSB side (shift right, new bit in at MSB), so the first sample of a word ends in bit 0.
  - Bit counter runs 0..WORD_W−1.
  - On the sample that moves the counter from WORD_W−1 to 0, the completed word (including that bit) is copied to data_o.
- en = 0:
  - No sampling.
  - Bit counter and partial shift register clear to 0.
  - data_o, tracker state and bpv_cnt_o hold.
  - All pulse outputs are 0.
- bpv_cnt_o: increments by 1 per violation, saturates at 2^CNT_W−1. Only reset clears it.
- Reset values: data_o = 0, data_valid_o = 0, bpv_o = 0, err_sym_o = 0, bpv_cnt_o = 0, tracker = NONE, bit counter = 0, shift register = 0.
- Reset asserted mid-word discards the partial word and returns the tracker to NONE.

## Timing
- A symbol is sampled at rising edge k when en = 1 at that edge.
- bpv_o and err_sym_o are registered. They are high during the cycle after edge k and low otherwise.
- A word completes when the WORD_W-th symbol since alignment is sampled at edge k:
  - data_o and data_valid_o update at edge k, so latency from last symbol to output is 1 edge.
  - data_valid_o stays high for exactly one cycle.
  - No gap is needed between words: back-to-back words give data_valid_o pulses exactly WORD_W cycles apart.
- The bpv_cnt_o increment is visible after the same edge as its bpv_o pulse.
- en falling:
  - A sample taken at the edge where en is still 1 counts.
  - From the first edge with en = 0 the counter is 0.
  - The next en = 1 edge samples bit 0 of a new word.
- Violation and word completion on the same sample: both pulses fire in the same cycle.

## Test plan
- Reset: drive sys_rst_n = 0 with en = 1 and ami_i toggling → all outputs 0. Release, then send 0-symbols only → no pulses, bpv_cnt_o = 0.
- Clean word: send 16'hA5C3 LSB-first with alternating marks starting at +1 (symbols +1,−1,0,0,0,0,+1,−1,+1,0,−1,0,0,+1,0,−1) → data_o = 16'hA5C3 with a single data_valid_o pulse one edge after the 16th symbol. bpv_o is never high.
- Violation: from reset send +1,0,+1 then 13 zeros → bpv_o pulses once, on the third symbol. bpv_cnt_o = 1 and data_o = 16'h0005.
- Illegal symbol: send +1, 2'b10, −1, then 13 zeros → err_sym_o pulses once and bpv_o never pulses (tracker unchanged). data_o = 16'h0005.
- Realignment: send 7 marks, drop en for 3 cycles, then send 16'h00FF correctly → no data_valid_o before the new word; data_o = 16'h00FF.
- Saturation and reset mid-word: send 300 consecutive +1 symbols → bpv_cnt_o ends at 255 (299 violations). Assert reset after 5 symbols of the next word → counter, tracker and data_o return to their reset values.

Source files
------------

// File: rtl/ami_decoder.sv
// AMI line decoder: marks decode to 1, zeros to 0, bits reassembled LSB-first
// into WORD_W-bit words, with bipolar-violation / illegal-symbol flags and a saturating count.
module ami_decoder #(
    parameter int unsigned WORD_W = 16,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                en,
    input  logic signed [1:0]   ami_i,
    output logic [WORD_W-1:0]   data_o,
    output logic                data_valid_o,
    output logic                bpv_o,
    output logic                err_sym_o,
    output logic [CNT_W-1:0]    bpv_cnt_o
);

    localparam int unsigned BCNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(WORD_W - 1);

    typedef enum logic [1:0] {
        ST_NONE = 2'd0,
        ST_POS  = 2'd1,
        ST_NEG  = 2'd2
    } pol_state_t;

    pol_state_t          r_state;
    pol_state_t          w_state_nxt;

    logic [1:0]          w_sym;
    logic                w_pos;
    logic                w_neg;
    logic                w_bit;
    logic                w_bpv;
    logic                w_illegal;
    logic [WORD_W-1:0]   w_shift_nxt;

    logic [WORD_W-1:0]   r_shift;
    logic [BCNT_W-1:0]   r_bit_cnt;
    logic [WORD_W-1:0]   r_data;
    logic                r_data_valid;
    logic                r_bpv;
    logic                r_err_sym;
    logic [CNT_W-1:0]    r_bpv_cnt;

    assign w_sym       = ami_i;
    assign w_pos       = (w_sym == 2'b01);
    assign w_neg       = (w_sym == 2'b11);
    assign w_shift_nxt = {w_bit, r_shift[WORD_W-1:1]};

    // Polarity tracker: state register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= ST_NONE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Polarity tracker: next state (zero and illegal symbols leave it unchanged)
    always_comb begin
        w_state_nxt = r_state;
        if (en) begin
            if (w_pos) begin
                w_state_nxt = ST_POS;
            end else if (w_neg) begin
                w_state_nxt = ST_NEG;
            end
        end
    end

    // Polarity tracker: decode outputs
    always_comb begin
        w_bit     = 1'b0;
        w_bpv     = 1'b0;
        w_illegal = 1'b0;
        if (en) begin
            w_bit     = w_pos | w_neg;
            w_illegal = (w_sym == 2'b10);
            w_bpv     = (w_pos && (r_state == ST_POS)) || (w_neg && (r_state == ST_NEG));
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_data       <= '0;
            r_data_valid <= 1'b0;
            r_bpv        <= 1'b0;
            r_err_sym    <= 1'b0;
            r_bpv_cnt    <= '0;
        end else begin
            r_data_valid <= 1'b0;
            r_bpv        <= w_bpv;
            r_err_sym    <= w_illegal;
            if (w_bpv && (r_bpv_cnt != '1)) begin
                r_bpv_cnt <= r_bpv_cnt + 1'b1;
            end
            if (!en) begin
                r_shift   <= '0;
                r_bit_cnt <= '0;
            end else if (r_bit_cnt == LAST_BIT) begin
                r_data       <= w_shift_nxt;
                r_data_valid <= 1'b1;
                r_shift      <= '0;
                r_bit_cnt    <= '0;
            end else begin
                r_shift   <= w_shift_nxt;
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

    assign data_o       = r_data;
    assign data_valid_o = r_data_valid;
    assign bpv_o        = r_bpv;
    assign err_sym_o    = r_err_sym;
    assign bpv_cnt_o    = r_bpv_cnt;

endmodule
